jpeg_coef_block_ctrl: RTL

JPEG_COEF_BLOCK_CTRL -- requirements
Module: jpeg_coef_block_ctrl

---
 rtl/jpeg_coef_block_ctrl.sv | 117 +++++++++++
 1 files changed

// File: rtl/jpeg_coef_block_ctrl.sv
// JPEG coefficient block controller: collects zigzag coefficients, dequantizes
// against one of two quant tables and presents the raster-order block.
module jpeg_coef_block_ctrl #(
   parameter int WIDTH_IN  = 16,
   parameter int WIDTH_OUT = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    coef_valid,
   output logic                    coef_ready,
   input  logic [5:0]              coef_idx,
   input  logic [WIDTH_IN-1:0]     coef_val,
   input  logic                    blk_end,
   input  logic                    blk_qsel,
   input  logic                    qt_wr,
   input  logic                    qt_tsel,
   input  logic [5:0]              qt_idx,
   input  logic [WIDTH_IN-1:0]     qt_val,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WIDTH_OUT*64-1:0] out_data,
   output logic [15:0]             blk_cnt
);

   typedef enum logic [1:0] {COLLECT, CALC, OUT} state_t;

   state_t                      state_reg, state_next;
   logic                        qsel_reg;
   logic [15:0]                 blk_cnt_reg;
   logic [WIDTH_OUT*64-1:0]     out_data_reg;
   logic [WIDTH_OUT*64-1:0]     calc_data;
   logic signed [WIDTH_IN-1:0]  coef_mem [64];
   logic [WIDTH_IN-1:0]         qt_mem [2][64];
   logic                        wr_accept;
   logic                        xfer;

   // Zigzag position of raster entry (r,c), walking anti-diagonals s = r + c.
   function automatic int zz_index(input int r, input int c);
      int s;
      int base;
      int off;
      s = r + c;
      if (s < 8) begin
         base = s * (s + 1) / 2;
         off  = (s % 2 == 1) ? r : c;
      end else begin
         base = 64 - (15 - s) * (16 - s) / 2;
         off  = (s % 2 == 1) ? r - (s - 7) : c - (s - 7);
      end
      return base + off;
   endfunction

   assign coef_ready = (state_reg == COLLECT);
   assign out_valid  = (state_reg == OUT);
   assign wr_accept  = coef_valid && coef_ready;
   assign xfer       = out_valid && out_ready;
   assign out_data   = out_data_reg;
   assign blk_cnt    = blk_cnt_reg;

   // Signed coefficient times zero-extended quant value, sign-extended to output width.
   for (genvar gi = 0; gi < 64; gi++) begin : g_pos
      localparam int ZZ = zz_index(gi / 8, gi % 8);
      logic signed [2*WIDTH_IN:0] prod;
      assign prod = $signed(coef_mem[ZZ]) * $signed({1'b0, qt_mem[qsel_reg][ZZ]});
      assign calc_data[gi*WIDTH_OUT +: WIDTH_OUT] = WIDTH_OUT'(prod);
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         COLLECT: if (wr_accept && blk_end) state_next = CALC;
         CALC:    state_next = OUT;
         OUT:     if (out_ready) state_next = COLLECT;
         default: state_next = COLLECT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= COLLECT;
         qsel_reg     <= 1'b0;
         blk_cnt_reg  <= '0;
         out_data_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (wr_accept && blk_end) qsel_reg <= blk_qsel;
         if (state_reg == CALC) begin
            out_data_reg <= calc_data;
         end else if (xfer) begin
            out_data_reg <= '0;
            blk_cnt_reg  <= blk_cnt_reg + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 64; i++) coef_mem[i] <= '0;
      end else if (xfer) begin
         for (int i = 0; i < 64; i++) coef_mem[i] <= '0;
      end else if (wr_accept) begin
         coef_mem[coef_idx] <= coef_val;
      end
   end

   // Table writes land after the edge, so a write alongside blk_end is seen by CALC
   // while a write during CALC only affects later blocks.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int t = 0; t < 2; t++)
            for (int i = 0; i < 64; i++) qt_mem[t][i] <= WIDTH_IN'(1);
      end else if (qt_wr) begin
         qt_mem[qt_tsel][qt_idx] <= qt_val;
      end
   end

endmodule
